slide_merge: RTL and testbench

//  2048-style move engine, directly upstream of pop_random.

---
 rtl/slide_merge.sv | 120 ++++++++++++
 tb/tb_slide_merge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/slide_merge.sv
// slide_merge: 2048 move engine that slides and merges one board line per clock
module slide_merge #(
  parameter int W  = 16,
  parameter int N  = 4,
  parameter int SW = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   dir,
  input  logic [N-1:0][N-1:0][W-1:0]   matrix_in,
  output logic                         busy,
  output logic                         done,
  output logic                         moved,
  output logic [SW-1:0]                score_delta,
  output logic [N-1:0][N-1:0][W-1:0]   matrix_out
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PROC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [W-1:0] TOP = {1'b1, {(W-1){1'b0}}};
  logic [1:0]                 state;
  logic [1:0]                 dir_q;
  logic [LW-1:0]              line;
  logic [N-1:0][N-1:0][W-1:0] work;
  logic [N-1:0][N-1:0][W-1:0] nxt;
  logic [SW-1:0]              score_acc;
  logic                       moved_acc;
  logic [N-1:0][W-1:0]        orig;
  logic [N:0][W-1:0]          cmp;
  logic [N-1:0][W-1:0]        res;
  logic [SW-1:0]              gain;
  logic                       diff;
  logic [LW:0]                k;
  logic                       skip;
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  // Pull the current line out of the work board with element 0 at the leading edge
  always_comb begin
    for (int j = 0; j < N; j++)
      orig[j] = (dir_q == 2'd0) ? work[line][j] :
                (dir_q == 2'd1) ? work[line][N-1-j] :
                (dir_q == 2'd2) ? work[j][line] : work[N-1-j][line];
  end
  // Compact non-zero tiles, then merge equal pairs once each; cmp[N] stays 0 as a sentinel
  always_comb begin
    cmp  = '0;
    res  = '0;
    gain = '0;
    k    = '0;
    skip = 1'b0;
    for (int i = 0; i < N; i++)
      if (orig[i] != '0) begin
        cmp[k] = orig[i];
        k = k + 1'b1;
      end
    k = '0;
    for (int i = 0; i < N; i++)
      if (skip)
        skip = 1'b0;
      else if (cmp[i] != '0 && cmp[i] == cmp[i+1] && cmp[i] != TOP) begin
        res[k[LW-1:0]] = cmp[i] << 1;
        gain = gain + (SW'(cmp[i]) << 1);
        k = k + 1'b1;
        skip = 1'b1;
      end else begin
        res[k[LW-1:0]] = cmp[i];
        k = k + 1'b1;
      end
    diff = (res != orig);
  end
  // Write the processed line back along the same mapping it was read from
  always_comb begin
    nxt = work;
    for (int j = 0; j < N; j++)
      if (dir_q == 2'd0)      nxt[line][j]     = res[j];
      else if (dir_q == 2'd1) nxt[line][N-1-j] = res[j];
      else if (dir_q == 2'd2) nxt[j][line]     = res[j];
      else                    nxt[N-1-j][line] = res[j];
  end
  // Move sequencing: latch in IDLE, one line per PROC edge, publish results on the last line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dir_q       <= '0;
      line        <= '0;
      work        <= '0;
      score_acc   <= '0;
      moved_acc   <= 1'b0;
      moved       <= 1'b0;
      score_delta <= '0;
      matrix_out  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          work      <= matrix_in;
          dir_q     <= dir;
          line      <= '0;
          score_acc <= '0;
          moved_acc <= 1'b0;
          state     <= PROC;
        end
        PROC: begin
          work      <= nxt;
          score_acc <= score_acc + gain;
          moved_acc <= moved_acc | diff;
          line      <= line + 1'b1;
          if (line == LW'(N-1)) begin
            state       <= DONE;
            matrix_out  <= nxt;
            moved       <= moved_acc | diff;
            score_delta <= score_acc + gain;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slide_merge.sv
// tb_slide_merge: randomized and directed checks of slide_merge against a queue-based move model
module tb_slide_merge;
  localparam int W = 16, N = 4, SW = 20;
  typedef logic [N-1:0][N-1:0][W-1:0] board_t;
  logic clk = 0, reset = 0, start = 0, busy, done, moved;
  logic [1:0] dir = 0;
  logic [SW-1:0] score_delta;
  board_t matrix_in = '0, matrix_out;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  slide_merge #(.W(W), .N(N), .SW(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .matrix_in(matrix_in),
    .busy(busy), .done(done), .moved(moved), .score_delta(score_delta), .matrix_out(matrix_out)
  );
  task automatic chk(input string tag, input logic [N*N*W-1:0] got, input logic [N*N*W-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int rr(input logic [1:0] d, input int i, input int j);
    return d < 2 ? i : (d == 2 ? j : N-1-j);
  endfunction
  function automatic int cc(input logic [1:0] d, input int i, input int j);
    return d == 0 ? j : (d == 1 ? N-1-j : i);
  endfunction
  function automatic void ref_move(input board_t b, input logic [1:0] d, output board_t o,
                                   output int sc, output bit mv);
    logic [W-1:0] q[$], r[$], v;
    o = b;
    sc = 0;
    for (int i = 0; i < N; i++) begin
      q = {};
      r = {};
      for (int j = 0; j < N; j++)
        if (b[rr(d,i,j)][cc(d,i,j)] != 0) q.push_back(b[rr(d,i,j)][cc(d,i,j)]);
      while (q.size() > 0) begin
        v = q.pop_front();
        if (q.size() > 0 && q[0] == v && v != 16'h8000) begin
          void'(q.pop_front());
          r.push_back(v * 2);
          sc += int'(v) * 2;
        end else r.push_back(v);
      end
      while (r.size() < N) r.push_back(0);
      for (int j = 0; j < N; j++) o[rr(d,i,j)][cc(d,i,j)] = r[j];
    end
    mv = (o != b);
  endfunction
  function automatic board_t rand_board();
    board_t b;
    int k;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        k = $urandom_range(0, 9);
        b[r][c] = k < 4 ? 16'd0 : (k == 9 ? 16'h8000 : 16'(1 << (k - 3)));
      end
    return b;
  endfunction
  task automatic move_check(input string tag, input board_t b, input logic [1:0] d);
    board_t e;
    int sc, lat;
    bit mv;
    ref_move(b, d, e, sc, mv);
    @(negedge clk);
    matrix_in = b;
    dir = d;
    start = 1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start = 0;
    matrix_in = rand_board();
    dir = 2'($urandom);
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = (lat == 1);
      matrix_in = rand_board();
    end
    start = 0;
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_board"}, matrix_out, e);
    chk({tag, "_moved"}, moved, mv);
    chk({tag, "_score"}, score_delta, sc);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done}, 2'b00);
  endtask
  initial begin
    board_t b, e;
    int cnt, sc;
    bit mv;
    repeat (3) @(negedge clk);
    chk("rst_flags", {busy, done, moved}, 3'b000);
    chk("rst_score", score_delta, 0);
    chk("rst_board", matrix_out, 0);
    reset = 1;
    @(negedge clk);
    matrix_in = rand_board();
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("abort_busy", busy, 1);
    reset = 0;
    @(negedge clk);
    chk("abort_flags", {busy, done, moved}, 3'b000);
    chk("abort_out", {matrix_out, score_delta}, 0);
    @(negedge clk);
    reset = 1;
    cnt = 0;
    repeat (8) begin @(negedge clk); cnt += done; end
    chk("abort_nodone", cnt, 0);
    chk("abort_idle", busy, 0);
    b = '0;
    for (int c = 0; c < N; c++) b[0][c] = 2;
    move_check("left2222", b, 0);
    e = '0; e[0][0] = 4; e[0][1] = 4;
    chk("left2222_exp", {matrix_out, score_delta, moved}, {e, 20'd8, 1'b1});
    b = '0; b[1][0] = 2; b[1][2] = 2; b[1][3] = 4;
    move_check("right2024", b, 1);
    e = '0; e[1][2] = 4; e[1][3] = 4;
    chk("right2024_exp", {matrix_out, score_delta}, {e, 20'd4});
    move_check("left2024", b, 0);
    e = '0; e[1][0] = 4; e[1][1] = 4;
    chk("left2024_exp", {matrix_out, score_delta}, {e, 20'd4});
    b = '0; b[1][2] = 8; b[2][2] = 8; b[3][2] = 16;
    move_check("up", b, 2);
    e = '0; e[0][2] = 16; e[1][2] = 16;
    chk("up_exp", {matrix_out, score_delta}, {e, 20'd16});
    b = '0; b[0][1] = 2; b[1][1] = 4; b[2][1] = 8; b[3][1] = 16;
    move_check("down_nomove", b, 3);
    chk("down_exp", {matrix_out, score_delta, moved}, {b, 20'd0, 1'b0});
    b = '0; b[0][0] = 16'h8000; b[0][1] = 16'h8000;
    move_check("overflow", b, 0);
    chk("overflow_exp", {matrix_out, score_delta, moved}, {b, 20'd0, 1'b0});
    b = rand_board();
    ref_move(b, 2'd1, e, sc, mv);
    @(negedge clk);
    matrix_in = b;
    dir = 1;
    start = 1;
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += done; end
    start = 0;
    repeat (15) begin @(negedge clk); cnt += done; end
    chk("held_start_dones", cnt, 2);
    chk("held_start_board", matrix_out, e);
    for (int t = 0; t < 40; t++) move_check($sformatf("rand%0d", t), rand_board(), 2'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
